phys_reg_free_list: RTL
=======================

# phys_reg_free_list

Renaming-stage free list for physical registers. It holds two circular FIFOs of unused physical register indices, one for data (D) registers and one for status (S) registers. Rename pops an index for each instruction that writes a register. The reorder buffer's commit port pushes back each retired instruction's previous physical mapping. Per-branch checkpoints of the allocation pointers let a mispredict restore the list in one cycle.

## Interface
Parameters:
- NUM_D_PHYS, 32: physical D registers; must be a power of two.
- NUM_D_ARCH, 16: architectural D registers; at reset these are mapped to physical 0..NUM_D_ARCH-1.
- NUM_S_PHYS, 16: physical S registers; must be a power of two.
- NUM_S_ARCH, 8: architectural S registers.
- NUM_CKPT, 4: number of checkpoint slots.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- alloc_r  in  1  rename consumes rw_addr this cycle
- alloc_s  in  1  rename consumes rs_addr this cycle
- rw_addr  out  $clog2(NUM_D_PHYS)  next free D register (head entry)
- rs_addr  out  $clog2(NUM_S_PHYS)  next free S register (head entry)
- r_empty  out  1  no free D register
- s_empty  out  1  no free S register
- return_r  in  1  commit frees r_addr
- r_addr  in  $clog2(NUM_D_PHYS)  freed D register
- return_s  in  1  commit frees s_addr
- s_addr  in  $clog2(NUM_S_PHYS)  freed S register
- ckpt_save  in  1  snapshot the head pointers into slot ckpt_save_id
- ckpt_save_id  in  $clog2(NUM_CKPT)  slot to write
- ckpt_restore  in  1  restore the head pointers from slot ckpt_restore_id
- ckpt_restore_id  in  $clog2(NUM_CKPT)  slot to read
- r_free_count  out  $clog2(NUM_D_PHYS)+1  free D entries
- s_free_count  out  $clog2(NUM_S_PHYS)+1  free S entries
- overflow_err  out  1  sticky; a return was made into a full list

## Operation
- Each list is an array of NUM_x_PHYS entries with a head (alloc) pointer and a tail (return) pointer.
  - Pointers are $clog2(NUM_x_PHYS) bits and wrap naturally modulo NUM_x_PHYS.
  - A separate wrap bit per pointer distinguishes full from empty.
  - Free count = {tail_wrap,tail} − {head_wrap,head}.
- Reset:
  - D entries i = 0..NUM_D_PHYS−NUM_D_ARCH−1 hold NUM_D_ARCH+i.
  - head = 0; tail = NUM_D_PHYS−NUM_D_ARCH; all wrap bits 0.
  - S list likewise with its own parameters.
  - overflow_err = 0; checkpoint slots = 0.
- Reset output values: rw_addr = NUM_D_ARCH, rs_addr = NUM_S_ARCH, r_empty = s_empty = 0, r_free_count = NUM_D_PHYS−NUM_D_ARCH, s_free_count = NUM_S_PHYS−NUM_S_ARCH.
- Allocate: alloc_r with r_empty = 0 advances head. alloc_r while r_empty = 1 is ignored; rename must stall on r_empty. S list is identical.
- Return: return_r writes r_addr at tail and advances tail.
  - If the list is full (count = NUM_D_PHYS), the write is dropped and overflow_err is set.
  - overflow_err clears only on reset.
- Simultaneous alloc and return on the same list: both pointers move; count is unchanged.
  - The returned index is not bypassed to rw_addr when the list is empty.
- Checkpoint save: stores the head pointers (D and S, with wrap bits) as they will be after this cycle's allocations.
  - Save is ignored when ckpt_restore is asserted in the same cycle.
- Checkpoint restore: sets both heads from the selected slot.
  - Allocations in the same cycle are ignored.
  - Returns in the same cycle are still performed; tails are never restored.
- D and S lists are fully independent apart from sharing the checkpoint control.

## Timing
- rw_addr, rs_addr, empty flags and counts are combinational from the registered pointers and array, so valid in the same cycle.
- An allocation takes effect at the next edge; the following head entry is visible one cycle later.
- A returned register is allocatable from the cycle after the return edge (1-cycle latency).
- Restore: restored head values are visible on the outputs the cycle after ckpt_restore.
- Synchronous reset mid-operation overrides all inputs in that cycle.

## Test plan
- Reset with default parameters:
  - rw_addr = 16, rs_addr = 8, r_free_count = 16, s_free_count = 8, r_empty = s_empty = 0, overflow_err = 0.
- Drain D with 16 back-to-back alloc_r:
  - rw_addr steps 16..31, then r_empty = 1 and count = 0.
  - A 17th alloc_r leaves all state unchanged.
- From empty D, return r_addr = 5:
  - Next cycle r_empty = 0, rw_addr = 5, count = 1.
- At D count 3, assert alloc_r and return_r (r_addr = 2) together:
  - Count stays 3; 2 is allocated after the existing entries.
- Checkpoint:
  - Save slot 1 at reset state.
  - Allocate D three times (16, 17, 18) while returning D register 3.
  - Restore slot 1 → rw_addr = 16, r_free_count = 17.
- Wrap and overflow:
  - Cycle D registers through the list for 40 alloc/return pairs; verify FIFO order holds across the index 31→0 wrap.
  - Fill the list to 32 and return once more → overflow_err = 1 and count stays 32.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Free list of physical D and S register indices for the rename stage.
// Two circular FIFOs with wrap-bit pointers plus per-branch head checkpoints.
module phys_reg_free_list #(
  parameter int NUM_D_PHYS = 32,
  parameter int NUM_D_ARCH = 16,
  parameter int NUM_S_PHYS = 16,
  parameter int NUM_S_ARCH = 8,
  parameter int NUM_CKPT   = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            alloc_r,
  input  logic                            alloc_s,
  output logic [$clog2(NUM_D_PHYS)-1:0]   rw_addr,
  output logic [$clog2(NUM_S_PHYS)-1:0]   rs_addr,
  output logic                            r_empty,
  output logic                            s_empty,
  input  logic                            return_r,
  input  logic [$clog2(NUM_D_PHYS)-1:0]   r_addr,
  input  logic                            return_s,
  input  logic [$clog2(NUM_S_PHYS)-1:0]   s_addr,
  input  logic                            ckpt_save,
  input  logic [$clog2(NUM_CKPT)-1:0]     ckpt_save_id,
  input  logic                            ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0]     ckpt_restore_id,
  output logic [$clog2(NUM_D_PHYS):0]     r_free_count,
  output logic [$clog2(NUM_S_PHYS):0]     s_free_count,
  output logic                            overflow_err
);
  localparam int DW = $clog2(NUM_D_PHYS);
  localparam int SW = $clog2(NUM_S_PHYS);

  logic [DW-1:0] d_mem [NUM_D_PHYS];
  logic [SW-1:0] s_mem [NUM_S_PHYS];

  // Pointers carry the wrap bit in their MSB so full and empty differ.
  logic [DW:0] d_head, d_tail, d_head_next, d_count;
  logic [SW:0] s_head, s_tail, s_head_next, s_count;
  logic [DW:0] ck_d [NUM_CKPT];
  logic [SW:0] ck_s [NUM_CKPT];

  logic d_full, s_full, d_alloc, s_alloc, d_push, s_push, save_en;

  always_comb begin
    d_count = d_tail - d_head;
    s_count = s_tail - s_head;
    r_empty = (d_count == '0);
    s_empty = (s_count == '0);
    d_full  = (d_count == (DW+1)'(NUM_D_PHYS));
    s_full  = (s_count == (SW+1)'(NUM_S_PHYS));
    rw_addr = d_mem[d_head[DW-1:0]];
    rs_addr = s_mem[s_head[SW-1:0]];
    r_free_count = d_count;
    s_free_count = s_count;
    // A restore overrides any allocation requested in the same cycle.
    d_alloc = alloc_r && !r_empty && !ckpt_restore;
    s_alloc = alloc_s && !s_empty && !ckpt_restore;
    d_push  = return_r && !d_full;
    s_push  = return_s && !s_full;
    save_en = ckpt_save && !ckpt_restore;
    d_head_next = ckpt_restore ? ck_d[ckpt_restore_id] : d_head + {{DW{1'b0}}, d_alloc};
    s_head_next = ckpt_restore ? ck_s[ckpt_restore_id] : s_head + {{SW{1'b0}}, s_alloc};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_D_PHYS; i++)
        d_mem[i] <= (i < NUM_D_PHYS - NUM_D_ARCH) ? DW'(NUM_D_ARCH + i) : '0;
      d_head <= '0;
      d_tail <= (DW+1)'(NUM_D_PHYS - NUM_D_ARCH);
    end else begin
      if (d_push) d_mem[d_tail[DW-1:0]] <= r_addr;
      d_tail <= d_tail + {{DW{1'b0}}, d_push};
      d_head <= d_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_S_PHYS; i++)
        s_mem[i] <= (i < NUM_S_PHYS - NUM_S_ARCH) ? SW'(NUM_S_ARCH + i) : '0;
      s_head <= '0;
      s_tail <= (SW+1)'(NUM_S_PHYS - NUM_S_ARCH);
    end else begin
      if (s_push) s_mem[s_tail[SW-1:0]] <= s_addr;
      s_tail <= s_tail + {{SW{1'b0}}, s_push};
      s_head <= s_head_next;
    end
  end

  // Checkpoints capture the post-allocation heads so a restore resumes after this cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        ck_d[i] <= '0;
        ck_s[i] <= '0;
      end
      overflow_err <= 1'b0;
    end else begin
      if (save_en) begin
        ck_d[ckpt_save_id] <= d_head_next;
        ck_s[ckpt_save_id] <= s_head_next;
      end
      if ((return_r && d_full) || (return_s && s_full)) overflow_err <= 1'b1;
    end
  end

endmodule
